dmem_cache_ctrl: RTL and testbench

// - Direct-mapped, write-through, no-write-allocate cache controller between the CPU load/store port and a

---
 rtl/dmem_cache_ctrl.sv | 132 +++++++++++++
 tb/tb_dmem_cache_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller with a req/ack memory port.
// Optional hit/miss counters are enabled by defining DMEM_CACHE_STATS_EN.
module dmem_cache_ctrl #(
    parameter  int ADDRESS_WIDTH = 32,
    parameter  int DATA_WIDTH    = 32,
    parameter  int SET_WIDTH     = 8,
    localparam int TAG_WIDTH     = ADDRESS_WIDTH - SET_WIDTH - 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     Req,
    input  logic                     we,
    input  logic                     ByteOp,
    input  logic [ADDRESS_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0]    WriteData,
    output logic [DATA_WIDTH-1:0]    ReadData,
    output logic                     Stall,
    output logic                     MemReq,
    output logic                     MemWe,
    output logic                     MemByteOp,
    output logic [ADDRESS_WIDTH-1:0] MemAddress,
    output logic [DATA_WIDTH-1:0]    MemWriteData,
    input  logic [DATA_WIDTH-1:0]    MemReadData,
    input  logic                     MemAck
`ifdef DMEM_CACHE_STATS_EN
    ,
    output logic [31:0]              HitCount,
    output logic [31:0]              MissCount
`endif
);

    localparam int NSETS = 2 ** SET_WIDTH;

    typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

    state_t                 state_q;
    logic [NSETS-1:0]       valid_q;
    logic [TAG_WIDTH-1:0]   tag_q  [NSETS];
    logic [DATA_WIDTH-1:0]  data_q [NSETS];

    logic [SET_WIDTH-1:0]   index;
    logic [TAG_WIDTH-1:0]   tag;
    logic [DATA_WIDTH-1:0]  line_w;
    logic [7:0]             line_byte;
    logic [DATA_WIDTH-1:0]  merged;
    logic                   hit;
    logic [4:0]             lane_lsb;

    assign index  = Address[SET_WIDTH+1:2];
    assign tag    = Address[ADDRESS_WIDTH-1:SET_WIDTH+2];
    assign line_w = data_q[index];
    assign hit    = valid_q[index] && (tag_q[index] == tag);

    // Big-endian lanes: byte offset 0 lives in the top byte of the word.
    assign lane_lsb  = {~Address[1:0], 3'b000};
    assign line_byte = line_w[lane_lsb +: 8];

    always_comb begin
        merged = WriteData;
        if (ByteOp) begin
            merged = line_w;
            merged[lane_lsb +: 8] = WriteData[7:0];
        end
    end

    always_comb begin
        ReadData = '0;
        if (!rst && !we && ((state_q == IDLE && Req && hit) || state_q == DONE))
            ReadData = ByteOp ? {{(DATA_WIDTH-8){1'b0}}, line_byte} : line_w;
    end

    assign Stall        = !rst && ((state_q == IDLE && Req && (we || !hit)) ||
                                   state_q == FETCH || state_q == WRITE);
    assign MemReq       = !rst && (state_q == FETCH || state_q == WRITE);
    assign MemWe        = !rst && (state_q == WRITE);
    assign MemByteOp    = !rst && (state_q == WRITE) && ByteOp;
    assign MemAddress   = (state_q == WRITE && ByteOp) ? Address
                                                       : {Address[ADDRESS_WIDTH-1:2], 2'b00};
    assign MemWriteData = WriteData;

    // The CPU holds its request stable while stalled, so index/tag/hit stay valid
    // through FETCH/WRITE and the line can be updated directly on MemAck.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (Req) begin
                        if (we)        state_q <= WRITE;
                        else if (!hit) state_q <= FETCH;
                    end
                end
                FETCH: begin
                    if (MemAck) begin
                        valid_q[index] <= 1'b1;
                        tag_q[index]   <= tag;
                        data_q[index]  <= MemReadData;
                        state_q        <= DONE;
                    end
                end
                WRITE: begin
                    if (MemAck) begin
                        if (hit) data_q[index] <= merged;
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DMEM_CACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == IDLE && Req && !we) begin
            if (hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
            else     miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign HitCount  = hit_cnt_q;
    assign MissCount = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_cache_ctrl.sv
// Bench for dmem_cache_ctrl: directed vector table, mid-fetch reset sequence, and random
// accesses scored against a memory/tag model. Stats checks apply when DMEM_CACHE_STATS_EN is set.
module tb_dmem_cache_ctrl;

    logic        clk, rst, Req, we, ByteOp;
    logic [31:0] Address, WriteData, ReadData;
    logic        Stall, MemReq, MemWe, MemByteOp;
    logic [31:0] MemAddress, MemWriteData, MemReadData;
    logic        MemAck;
`ifdef DMEM_CACHE_STATS_EN
    logic [31:0] HitCount, MissCount;
`endif

    dmem_cache_ctrl dut (
        .clk(clk), .rst(rst), .Req(Req), .we(we), .ByteOp(ByteOp),
        .Address(Address), .WriteData(WriteData), .ReadData(ReadData),
        .Stall(Stall), .MemReq(MemReq), .MemWe(MemWe), .MemByteOp(MemByteOp),
        .MemAddress(MemAddress), .MemWriteData(MemWriteData),
        .MemReadData(MemReadData), .MemAck(MemAck)
`ifdef DMEM_CACHE_STATS_EN
        , .HitCount(HitCount), .MissCount(MissCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Backing memory, keyed by word address; unwritten words read a fixed pattern.
    logic [31:0] mem [logic [29:0]];
    // Cache residency model (loads allocate, stores never do).
    bit          mv [256];
    logic [21:0] mt [256];
    int          hm, mm;

    typedef struct {
        logic        w;
        logic        b;
        logic [31:0] a;
        logic [31:0] d;
        int          lat;
        logic [31:0] rd;
        int          stl;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a[31:2])) return mem[a[31:2]];
        return {a[31:2], 2'b00} ^ 32'hA5C3_0F1E;
    endfunction

    task automatic mem_wr(input logic [31:0] a, input logic [31:0] d, input logic b);
        logic [31:0] cur;
        cur = mem_rd(a);
        if (b) cur[(3 - a[1:0]) * 8 +: 8] = d[7:0];
        else   cur = d;
        mem[a[31:2]] = cur;
    endtask

    // Drives one CPU access and plays the memory side; ack comes lat cycles after first MemReq.
    task automatic run(input string nm, input logic w, input logic b, input logic [31:0] a,
                       input logic [31:0] d, input int lat,
                       input logic [31:0] exp_rd, input int exp_stl);
        int          reqc, stl;
        bit          attr_ok, done;
        logic [31:0] exp_ma, rd;
        exp_ma = (w && b) ? a : {a[31:2], 2'b00};
        Req = 1'b1; we = w; ByteOp = b; Address = a; WriteData = d; MemAck = 1'b0;
        reqc = 0; stl = 0; attr_ok = 1'b1; done = 1'b0; rd = '0;
        for (int c = 0; c < 100 && !done; c++) begin
            MemReadData = mem_rd(a);
            @(negedge clk);
            if (!Stall) begin
                rd = ReadData;
                done = 1'b1;
                chk({nm, ".noreq_retire"}, {31'b0, MemReq}, 32'd0);
            end else begin
                stl++;
                if (MemReq) begin
                    if (MemWe !== w || MemAddress !== exp_ma || MemByteOp !== (w & b) ||
                        (w && MemWriteData !== d))
                        attr_ok = 1'b0;
                    if (reqc == lat) begin
                        MemAck = 1'b1;
                        if (w) mem_wr(a, d, b);
                    end
                    reqc++;
                end
            end
            @(posedge clk); #1;
            MemAck = 1'b0;
        end
        Req = 1'b0;
        chk({nm, ".completed"}, {31'b0, done}, 32'd1);
        chk({nm, ".rdata"}, rd, exp_rd);
        chk({nm, ".stall_cycles"}, stl, exp_stl);
        chk({nm, ".req_cycles"}, reqc, (exp_stl == 0) ? 0 : lat + 1);
        chk({nm, ".mem_attr"}, {31'b0, attr_ok}, 32'd1);
    endtask

    task automatic model_access(input logic w, input logic b, input logic [31:0] a,
                                input logic [31:0] d, input int lat);
        logic [7:0]  idx;
        logic [21:0] tg;
        logic [31:0] word, exp_rd;
        bit          hit;
        idx  = a[9:2];
        tg   = a[31:10];
        hit  = !w && mv[idx] && (mt[idx] == tg);
        word = mem_rd(a);
        if (w)      exp_rd = '0;
        else if (b) exp_rd = {24'b0, word[(3 - a[1:0]) * 8 +: 8]};
        else        exp_rd = word;
        run("rand", w, b, a, d, lat, exp_rd, hit ? 0 : lat + 2);
        if (!w) begin
            if (hit) hm++;
            else begin
                mm++;
                mv[idx] = 1'b1;
                mt[idx] = tg;
            end
        end
    endtask

    vec_t tbl[10];

    initial begin
        bit seen;
        tbl[0] = '{1'b0, 1'b0, 32'h0001_0000, 32'h0,         3, 32'hDEAD_BEEF, 5};
        tbl[1] = '{1'b0, 1'b0, 32'h0001_0000, 32'h0,         0, 32'hDEAD_BEEF, 0};
        tbl[2] = '{1'b1, 1'b1, 32'h0001_0001, 32'h0000_00AA, 2, 32'h0,         4};
        tbl[3] = '{1'b0, 1'b0, 32'h0001_0000, 32'h0,         0, 32'hDEAA_BEEF, 0};
        tbl[4] = '{1'b0, 1'b0, 32'h0001_0400, 32'h0,         1, 32'h1234_5678, 3};
        tbl[5] = '{1'b0, 1'b0, 32'h0001_0000, 32'h0,         2, 32'hDEAA_BEEF, 4};
        tbl[6] = '{1'b0, 1'b1, 32'h0001_0003, 32'h0,         0, 32'h0000_00EF, 0};
        tbl[7] = '{1'b1, 1'b0, 32'h0001_0004, 32'hCAFE_F00D, 0, 32'h0,         2};
        tbl[8] = '{1'b0, 1'b0, 32'h0001_0004, 32'h0,         1, 32'hCAFE_F00D, 3};
        tbl[9] = '{1'b1, 1'b0, 32'h0001_0000, 32'h0102_0304, 1, 32'h0,         3};
        mem[30'h0000_4000] = 32'hDEAD_BEEF;
        mem[30'h0000_4100] = 32'h1234_5678;

        rst = 1'b1; Req = 1'b0; we = 1'b0; ByteOp = 1'b0; Address = '0; WriteData = '0;
        MemReadData = '0; MemAck = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset.stall",   {31'b0, Stall},     32'd0);
        chk("reset.memreq",  {31'b0, MemReq},    32'd0);
        chk("reset.memwe",   {31'b0, MemWe},     32'd0);
        chk("reset.membyte", {31'b0, MemByteOp}, 32'd0);
        chk("reset.rdata",   ReadData,           32'd0);
`ifdef DMEM_CACHE_STATS_EN
        chk("reset.hitcount",  HitCount,  32'd0);
        chk("reset.misscount", MissCount, 32'd0);
`endif
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run($sformatf("vec%0d", i), tbl[i].w, tbl[i].b, tbl[i].a, tbl[i].d, tbl[i].lat,
                tbl[i].rd, tbl[i].stl);
`ifdef DMEM_CACHE_STATS_EN
            if (i == 5) begin
                chk("stats.hitcount",  HitCount,  32'd2);
                chk("stats.misscount", MissCount, 32'd3);
            end
`endif
        end
        run("store_hit_reload", 1'b0, 1'b0, 32'h0001_0000, 32'h0, 0, 32'h0102_0304, 0);

        // Reset while a fetch is outstanding; the late ack must not fill the line.
        Req = 1'b1; we = 1'b0; ByteOp = 1'b0; Address = 32'h0001_0800;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (MemReq) seen = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("rstseq.fetch_started", {31'b0, seen}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; Req = 1'b0; MemAck = 1'b1; MemReadData = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("rstseq.memreq", {31'b0, MemReq}, 32'd0);
        chk("rstseq.stall",  {31'b0, Stall},  32'd0);
        chk("rstseq.rdata",  ReadData,        32'd0);
        @(posedge clk); #1;
        MemAck = 1'b0;

        for (int i = 0; i < 256; i++) mv[i] = 1'b0;
        hm = 0; mm = 0;
        model_access(1'b0, 1'b0, 32'h0001_0800, 32'h0, 1);
        model_access(1'b0, 1'b0, 32'h0001_0000, 32'h0, 2);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = (32'(32'h40 + $urandom_range(0, 3)) << 10) |
                (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            model_access($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 40, a,
                         $urandom, $urandom_range(0, 4));
        end
`ifdef DMEM_CACHE_STATS_EN
        chk("rand.hitcount",  HitCount,  hm);
        chk("rand.misscount", MissCount, mm);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
